// File: rtl/data_mem_ctrl.sv
// Data RAM initiator: one load/store per request, optional pointer indirection, ready timeout.
// Define DATA_MEM_CTRL_HW_INDIRECT_EN to let the RAM resolve pointers on indirect loads.
module data_mem_ctrl #(
  parameter int width   = 16,
  parameter int length  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic              indirect,
  input  logic [length-1:0] addr,
  input  logic [width-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [width-1:0]  rdata,
  output logic              mem_indirect,
  output logic              mem_we,
  output logic              mem_re,
  output logic [length-1:0] mem_addr,
  output logic [width-1:0]  mem_wdata,
  input  logic              mem_ready,
  input  logic [width-1:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_PTR, GAP, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d, to_q, to_d, busy_q, busy_d;
  logic [length-1:0] addr_q, addr_d;
  logic [width-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, err_q, mem_re_q, mem_we_q;
  logic [length-1:0] mem_addr_q;
  logic [width-1:0]  mem_wdata_q;
  logic              re_d, wr_d;
`ifdef DATA_MEM_CTRL_HW_INDIRECT_EN
  logic              hw_q, hw_d, mem_ind_q;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    to_d    = to_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef DATA_MEM_CTRL_HW_INDIRECT_EN
    hw_d    = hw_q;
`endif
    case (state_q)
      IDLE: begin
        // busy drops on the edge where done falls; acceptance needs busy already low
        if (done_q) busy_d = 1'b0;
        else if (req && !busy_q) begin
          busy_d  = 1'b1;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          to_d    = 1'b0;
`ifdef DATA_MEM_CTRL_HW_INDIRECT_EN
          hw_d    = indirect && !we;
          if (indirect && !we) state_d = RD;
          else if (indirect)   state_d = RD_PTR;
          else                 state_d = we ? WR : RD;
`else
          if (indirect) state_d = RD_PTR;
          else          state_d = we ? WR : RD;
`endif
        end
      end
      RD_PTR, RD: begin
        if (mem_ready) begin
          if (state_q == RD_PTR) begin
            addr_d  = mem_rdata[length-1:0];
            state_d = GAP;
          end else begin
            rdata_d = mem_rdata;
            state_d = DONE;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = we_q ? WR : RD;
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM pins are registered from the next state so a phase starts on its entry edge
  assign re_d = (state_d == RD_PTR) || (state_d == RD);
  assign wr_d = (state_d == WR);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      to_q        <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef DATA_MEM_CTRL_HW_INDIRECT_EN
      hw_q        <= 1'b0;
      mem_ind_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      to_q        <= to_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      done_q      <= (state_q == DONE);
      err_q       <= (state_q == DONE) && to_q;
      mem_re_q    <= re_d;
      mem_we_q    <= wr_d;
      mem_addr_q  <= (re_d || wr_d) ? addr_d : '0;
      mem_wdata_q <= wr_d ? wdata_d : '0;
`ifdef DATA_MEM_CTRL_HW_INDIRECT_EN
      hw_q        <= hw_d;
      mem_ind_q   <= (state_d == RD) && hw_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef DATA_MEM_CTRL_HW_INDIRECT_EN
  assign mem_indirect = mem_ind_q;
`else
  assign mem_indirect = 1'b0;
`endif

endmodule
